conversor_paralelo_serie_4bits: RTL

Parallel-to-serial converter (PISO) that takes a WIDTH-bit word on a load/ready handshake and shifts it out one bit per clock. It also flags valid data and the last bit of each frame. It is the transmit-side counterpart of conversor_serie_paralelo_4bits and feeds that block's serial input in loopback tests. It supports back-to-back frames with no idle gap.

---
 rtl/conversor_paralelo_serie_4bits.sv | 86 ++++++++
 1 files changed

// File: rtl/conversor_paralelo_serie_4bits.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word on a load/ready
// handshake and emits it one bit per clock, flagging valid bits and the
// final bit of each frame. Back-to-back frames chain with no idle gap.
module conversor_paralelo_serie_4bits #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic shifting;
    logic accept;

    // Outputs are decoded from state only, so reset drops them immediately.
    always_comb begin
        shifting = (state_q == S_SHIFT);
        last     = shifting && (cnt_q == CNT_LAST);
        q_valid  = shifting;
        q        = shifting && (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
        ready    = !shifting || last;
        accept   = load && ready;
    end

    // Next-state: load in IDLE, shift toward output end, reload or retire at frame end.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sr_d    = d;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            default: begin
                if (last) begin
                    if (accept) begin
                        // Chain the next word directly behind the final bit.
                        sr_d  = d;
                        cnt_d = '0;
                    end else begin
                        sr_d    = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    sr_d  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
